// File: rtl/prescaled_timer.sv
// Purpose: down-counting timer clocked by a 2^sel prescaler, with sticky expiry and overrun flags.
// Latency: go/stop/int_ack act on the edge that samples them; expiry after (N+1)*2^sel edges.
// Backpressure: none; strobes are single-cycle controls and all outputs are registered.
module prescaled_timer #(
    parameter int TMR_WIDTH   = 16,
    parameter int PRESC_WIDTH = 8,
    parameter int SEL_WIDTH   = 3
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [SEL_WIDTH-1:0] prescaler_conf,
    input  logic [TMR_WIDTH-1:0] timer_conf,
    input  logic                 mode,
    input  logic                 go,
    input  logic                 stop,
    input  logic                 int_ack,
    output logic                 tmr_int,
    output logic                 ovr,
    output logic                 running,
    output logic [TMR_WIDTH-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [PRESC_WIDTH-1:0] prescaler;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [PRESC_WIDTH-1:0] sel_mask;
    logic                   tick;
    logic                   expiry;

    // Low sel_q bits of the prescaler; selects above PRESC_WIDTH saturate to a full mask.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < PRESC_WIDTH; i++) begin
            if (i < int'(sel_q)) begin
                sel_mask[i] = 1'b1;
            end
        end
    end

    // A tick fires when the selected prescaler bits are all ones; a stop cancels expiry.
    always_comb begin
        tick   = (state == RUN) && ((prescaler & sel_mask) == sel_mask);
        expiry = tick && (count == '0) && !stop;
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: stop beats go, go beats expiry, one-shot expiry returns to IDLE.
    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = IDLE;
        end else if (go) begin
            next_state = RUN;
        end else if (expiry && !mode) begin
            next_state = IDLE;
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        running = (state == RUN);
    end

    // Prescaler, latched select and down-counter.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            sel_q     <= '0;
            count     <= '0;
        end else if (stop) begin
            prescaler <= '0;
            count     <= '0;
        end else if (go) begin
            prescaler <= '0;
            sel_q     <= prescaler_conf;
            count     <= timer_conf;
        end else if (state == RUN) begin
            if (expiry && !mode) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (tick) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else if (mode) begin
                    count <= timer_conf;
                end
            end
        end else begin
            prescaler <= '0;
        end
    end

    // Sticky flags: expiry wins over ack for tmr_int, ack wins for ovr.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tmr_int <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (expiry) begin
                tmr_int <= 1'b1;
            end else if (int_ack) begin
                tmr_int <= 1'b0;
            end
            if (int_ack) begin
                ovr <= 1'b0;
            end else if (expiry && tmr_int) begin
                ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prescaled_timer.sv
// Purpose: scoreboard bench for prescaled_timer (default and narrow parameter sets).
// Latency: expectations are tagged with the clock edge count at which they must hold.
// Backpressure: none; the monitor checks every tagged entry on the falling edge.
module tb_prescaled_timer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  prescaler_conf = '0;
    logic [15:0] timer_conf = '0;
    logic        mode = 1'b0, go = 1'b0, stop = 1'b0, int_ack = 1'b0;
    logic        tmr_int, ovr, running;
    logic [15:0] count;

    logic [2:0]  prescaler_conf2 = '0;
    logic [7:0]  timer_conf2 = '0;
    logic        mode2 = 1'b0, go2 = 1'b0, stop2 = 1'b0, int_ack2 = 1'b0;
    logic        tmr_int2, ovr2, running2;
    logic [7:0]  count2;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        string       name;
        int          cyc;
        int          inst;
        logic        i;
        logic        o;
        logic        r;
        logic [15:0] c;
    } exp_t;

    exp_t q[$];

    prescaled_timer dut (
        .clk_in(clk_in), .rst(rst), .prescaler_conf(prescaler_conf), .timer_conf(timer_conf),
        .mode(mode), .go(go), .stop(stop), .int_ack(int_ack),
        .tmr_int(tmr_int), .ovr(ovr), .running(running), .count(count)
    );

    prescaled_timer #(.TMR_WIDTH(8), .PRESC_WIDTH(4), .SEL_WIDTH(3)) dut2 (
        .clk_in(clk_in), .rst(rst), .prescaler_conf(prescaler_conf2), .timer_conf(timer_conf2),
        .mode(mode2), .go(go2), .stop(stop2), .int_ack(int_ack2),
        .tmr_int(tmr_int2), .ovr(ovr2), .running(running2), .count(count2)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: compare every entry due this cycle; entries left behind count as missed.
    always @(negedge clk_in) begin
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].cyc <= cyc) begin
                automatic logic        ai = (q[k].inst == 0) ? tmr_int : tmr_int2;
                automatic logic        ao = (q[k].inst == 0) ? ovr : ovr2;
                automatic logic        ar = (q[k].inst == 0) ? running : running2;
                automatic logic [15:0] ac = (q[k].inst == 0) ? count : {8'h00, count2};
                total++;
                if (q[k].cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: check for cycle %0d missed (now %0d)", q[k].name, q[k].cyc, cyc);
                end else if (ai !== q[k].i || ao !== q[k].o || ar !== q[k].r || ac !== q[k].c) begin
                    bad++;
                    $display("FAIL %s inst%0d cyc%0d: got int=%0b ovr=%0b run=%0b cnt=%0d, want int=%0b ovr=%0b run=%0b cnt=%0d",
                             q[k].name, q[k].inst, cyc, ai, ao, ar, ac, q[k].i, q[k].o, q[k].r, q[k].c);
                end
                q.delete(k);
            end
        end
    end

    task automatic expect_at(input string n, input int inst, input int c,
                             input logic i, input logic o, input logic r, input int cnt);
        exp_t e;
        e.name = n; e.cyc = c; e.inst = inst;
        e.i = i; e.o = o; e.r = r; e.c = 16'(cnt);
        q.push_back(e);
    endtask

    // Leaves the caller 1 time unit after the edge that makes cyc == c.
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int e;
        int t;

        // Reset state and staying idle afterwards.
        wait_cyc(2);
        expect_at("rst0", 0, 2, 0, 0, 0, 0);
        expect_at("rst1", 1, 2, 0, 0, 0, 0);
        wait_cyc(3);
        rst = 1'b0;
        expect_at("idle_after_rst", 0, 6, 0, 0, 0, 0);
        wait_cyc(7);

        // One-shot, sel 0, N 0.
        e = cyc + 1;
        prescaler_conf = 3'd0; timer_conf = 16'd0; mode = 1'b0; go = 1'b1;
        expect_at("A_run", 0, e, 0, 0, 1, 0);
        expect_at("A_exp", 0, e + 1, 1, 0, 0, 0);
        expect_at("A_sticky", 0, e + 3, 1, 0, 0, 0);
        wait_cyc(e);
        go = 1'b0;
        wait_cyc(e + 4);
        expect_at("A_rst", 0, e + 4, 0, 0, 0, 0);
        do_reset();

        // Prescaled one-shot, sel 1, N 3; a select change after go must not matter.
        e = cyc + 1;
        prescaler_conf = 3'd1; timer_conf = 16'd3; mode = 1'b0; go = 1'b1;
        expect_at("B_c3a", 0, e, 0, 0, 1, 3);
        expect_at("B_c3b", 0, e + 1, 0, 0, 1, 3);
        expect_at("B_c2", 0, e + 2, 0, 0, 1, 2);
        expect_at("B_c1", 0, e + 4, 0, 0, 1, 1);
        expect_at("B_c0", 0, e + 6, 0, 0, 1, 0);
        expect_at("B_pre", 0, e + 7, 0, 0, 1, 0);
        expect_at("B_exp", 0, e + 8, 1, 0, 0, 0);
        expect_at("B_idle", 0, e + 10, 1, 0, 0, 0);
        wait_cyc(e);
        go = 1'b0;
        prescaler_conf = 3'd0;
        wait_cyc(e + 12);
        do_reset();

        // Auto-reload, sel 2, N 4, overrun, ack, then mode switched to one-shot.
        e = cyc + 1;
        prescaler_conf = 3'd2; timer_conf = 16'd4; mode = 1'b1; go = 1'b1;
        expect_at("C_c0", 0, e + 16, 0, 0, 1, 0);
        expect_at("C_pre", 0, e + 19, 0, 0, 1, 0);
        expect_at("C_exp1", 0, e + 20, 1, 0, 1, 4);
        expect_at("C_c3", 0, e + 24, 1, 0, 1, 3);
        expect_at("C_pre2", 0, e + 39, 1, 0, 1, 0);
        expect_at("C_ovr", 0, e + 40, 1, 1, 1, 4);
        expect_at("C_preack", 0, e + 44, 1, 1, 1, 3);
        expect_at("C_ack", 0, e + 45, 0, 0, 1, 3);
        expect_at("C_pre3", 0, e + 59, 0, 0, 1, 0);
        expect_at("C_exp3", 0, e + 60, 1, 0, 1, 4);
        expect_at("C_pre4", 0, e + 79, 1, 0, 1, 0);
        expect_at("C_mode0", 0, e + 80, 1, 1, 0, 0);
        wait_cyc(e);
        go = 1'b0;
        wait_cyc(e + 44);
        int_ack = 1'b1;
        wait_cyc(e + 45);
        int_ack = 1'b0;
        wait_cyc(e + 61);
        mode = 1'b0;
        wait_cyc(e + 82);
        do_reset();

        // Restart mid-run, then go together with stop.
        e = cyc + 1;
        prescaler_conf = 3'd0; timer_conf = 16'd10; mode = 1'b0; go = 1'b1;
        expect_at("D_c6", 0, e + 4, 0, 0, 1, 6);
        expect_at("D_reload", 0, e + 5, 0, 0, 1, 10);
        expect_at("D_c9", 0, e + 6, 0, 0, 1, 9);
        expect_at("D_delayed", 0, e + 11, 0, 0, 1, 4);
        expect_at("D_c0", 0, e + 15, 0, 0, 1, 0);
        expect_at("D_exp", 0, e + 16, 1, 0, 0, 0);
        expect_at("D_go", 0, e + 18, 1, 0, 1, 10);
        expect_at("D_c9b", 0, e + 19, 1, 0, 1, 9);
        expect_at("D_gostop", 0, e + 20, 1, 0, 0, 0);
        expect_at("D_hold", 0, e + 22, 1, 0, 0, 0);
        wait_cyc(e);
        go = 1'b0;
        wait_cyc(e + 4);
        go = 1'b1;
        wait_cyc(e + 5);
        go = 1'b0;
        wait_cyc(e + 17);
        go = 1'b1;
        wait_cyc(e + 18);
        go = 1'b0;
        wait_cyc(e + 19);
        go = 1'b1; stop = 1'b1;
        wait_cyc(e + 20);
        go = 1'b0; stop = 1'b0;
        wait_cyc(e + 23);
        do_reset();

        // Ack on the expiry edge, overrun, go on an expiry edge, stop keeps flags.
        e = cyc + 1;
        prescaler_conf = 3'd0; timer_conf = 16'd1; mode = 1'b1; go = 1'b1;
        expect_at("E_exp1", 0, e + 2, 1, 0, 1, 1);
        expect_at("E_c0", 0, e + 3, 1, 0, 1, 0);
        expect_at("E_collide", 0, e + 4, 1, 0, 1, 1);
        expect_at("E_ovr", 0, e + 6, 1, 1, 1, 1);
        expect_at("E_ack", 0, e + 7, 0, 0, 1, 0);
        expect_at("E_exp4", 0, e + 8, 1, 0, 1, 1);
        expect_at("E_goexp", 0, e + 10, 1, 1, 1, 5);
        expect_at("E_c4", 0, e + 11, 1, 1, 1, 4);
        expect_at("E_stop", 0, e + 12, 1, 1, 0, 0);
        wait_cyc(e);
        go = 1'b0;
        wait_cyc(e + 3);
        int_ack = 1'b1;
        wait_cyc(e + 4);
        int_ack = 1'b0;
        wait_cyc(e + 6);
        int_ack = 1'b1;
        wait_cyc(e + 7);
        int_ack = 1'b0;
        wait_cyc(e + 9);
        go = 1'b1; timer_conf = 16'd5;
        wait_cyc(e + 10);
        go = 1'b0;
        wait_cyc(e + 11);
        stop = 1'b1;
        wait_cyc(e + 12);
        stop = 1'b0;
        wait_cyc(e + 13);
        do_reset();

        // Narrow instance: sel 7 clamps to divide-by-16; then async reset mid-run.
        e = cyc + 1;
        prescaler_conf2 = 3'd7; timer_conf2 = 8'd2; mode2 = 1'b0; go2 = 1'b1;
        expect_at("F_start", 1, e, 0, 0, 1, 2);
        expect_at("F_pre", 1, e + 15, 0, 0, 1, 2);
        expect_at("F_c1", 1, e + 16, 0, 0, 1, 1);
        expect_at("F_c0", 1, e + 47, 0, 0, 1, 0);
        expect_at("F_exp", 1, e + 48, 1, 0, 0, 0);
        expect_at("F_mid", 1, e + 59, 1, 0, 1, 2);
        expect_at("F_arst", 1, e + 60, 0, 0, 0, 0);
        expect_at("F_arst_main", 0, e + 60, 0, 0, 0, 0);
        expect_at("F_nopend", 1, e + 62, 0, 0, 0, 0);
        wait_cyc(e);
        go2 = 1'b0;
        wait_cyc(e + 49);
        mode2 = 1'b1; go2 = 1'b1;
        wait_cyc(e + 50);
        go2 = 1'b0;
        wait_cyc(e + 60);
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // Drain the scoreboard with a bounded wait.
        t = cyc + 20;
        while (q.size() != 0 && cyc < t) begin
            @(posedge clk_in);
            #1;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks still pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prescaled_timer.md
PRESCALED_TIMER -- requirements
Module: prescaled_timer

Interface
REQ-001 SHALL have parameter TMR_WIDTH, default 16: width of the reload value and the down-counter.
REQ-002 SHALL have parameter PRESC_WIDTH, default 8: width of the free prescaler counter.
REQ-003 SHALL have parameter SEL_WIDTH, default 3: width of the prescaler select.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port prescaler_conf, input, SEL_WIDTH bits: selects divide ratio 2^sel.
REQ-007 SHALL have port timer_conf, input, TMR_WIDTH bits: reload value N.
REQ-008 SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = auto-reload.
REQ-009 SHALL have port go, input, 1 bit: start/restart strobe.
REQ-010 SHALL have port stop, input, 1 bit: abort strobe.
REQ-011 SHALL have port int_ack, input, 1 bit: clears the tmr_int and ovr flags.
REQ-012 SHALL have port tmr_int, output, 1 bit: sticky expiry flag.
REQ-013 SHALL have port ovr, output, 1 bit: sticky flag, set when an expiry occurs while tmr_int is already set.
REQ-014 SHALL have port running, output, 1 bit: high in state RUN.
REQ-015 SHALL have port count, output, TMR_WIDTH bits: current down-counter value.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and RUN, with running = (state == RUN).
REQ-017 On go with stop low, in either state, SHALL on that edge:
- load count <= timer_conf
- clear the prescaler to 0
- latch prescaler_conf into sel_q
- enter RUN
A go in RUN is a restart.
REQ-018 On stop, in either state, SHALL enter IDLE and set count <= 0; stop overrides go when both are asserted together; tmr_int and ovr are unaffected.
REQ-019 In IDLE, the prescaler SHALL hold 0 and count SHALL hold its value.
REQ-020 In RUN, the prescaler SHALL increment by 1 each cycle, modulo 2^PRESC_WIDTH.
REQ-021 A tick SHALL occur in a RUN cycle when prescaler[sel_q-1:0] is all ones; with sel_q = 0, every RUN cycle is a tick.
REQ-022 A sel_q value of PRESC_WIDTH or more SHALL be clamped to PRESC_WIDTH, i.e. divide by 2^PRESC_WIDTH.
REQ-023 On a tick with count != 0, count SHALL decrement by 1; there is no wrap below 0.
REQ-024 On a tick with count == 0 (expiry):
- set tmr_int
- in mode 1: reload count <= timer_conf (sampled live) and stay in RUN
- in mode 0: stay at count = 0 and enter IDLE
REQ-025 Period SHALL be (N+1)*2^sel cycles: tmr_int rises exactly (N+1)*2^sel clock edges after the edge that samples go; in mode 1 it repeats every (N+1)*2^sel cycles thereafter.
REQ-026 The mode input SHALL be sampled at each expiry.
REQ-027 prescaler_conf changes SHALL take effect only at the next go.
REQ-028 int_ack SHALL clear tmr_int and ovr on the next edge.
REQ-029 When expiry and int_ack coincide, tmr_int SHALL be set (set wins) and ovr SHALL be cleared.
REQ-030 Expiry while tmr_int = 1 and int_ack = 0 SHALL set ovr.
REQ-031 A go coinciding with expiry SHALL take priority: reload from go, with tmr_int still set by the expiry.
REQ-032 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-033 rst high SHALL asynchronously force:
- state IDLE
- prescaler 0
- sel_q 0
- count 0
- tmr_int 0
- ovr 0
- running 0
REQ-034 rst asserted mid-count SHALL abort the operation immediately with no pending expiry.
REQ-035 After rst deasserts, the block SHALL remain in IDLE until go.

Verification
REQ-036 Scenario, one-shot basic: sel=0, N=0, mode 0, go 1 cycle -> tmr_int high 1 edge later, running low, count 0.
REQ-037 Scenario, prescaled one-shot: sel=1, N=3, mode 0 -> count steps 3,2,1,0 every 2 cycles; tmr_int rises exactly 8 edges after go; then IDLE.
REQ-038 Scenario, auto-reload with overrun: sel=2, N=4, mode 1, no ack -> tmr_int at edge 20; ovr at edge 40; int_ack at edge 45 clears both; tmr_int sets again at edge 60.
REQ-039 Scenario, restart/stop priority:
- go at edge 5 of a N=10 run reloads count to 10 and delays expiry accordingly
- go and stop together -> IDLE, count 0
REQ-040 Scenario, ack/expiry collision: int_ack on the expiry edge -> tmr_int stays 1, ovr 0.
REQ-041 Scenario, parameters and reset: TMR_WIDTH=8, PRESC_WIDTH=4, sel=7 -> period (N+1)*16; async rst pulse between edges mid-run -> all outputs 0 before the next edge.
